lcd_frame_sequencer: RTL and testbench



---
 rtl/lcd_frame_sequencer_if.sv | 19 +
 rtl/lcd_frame_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_sequencer_if.sv
// Word stream from the frame sequencer to the HD44780 byte driver.
// The master presents {RS,DATA} words; the slave accepts them with out_ready.
interface lcd_frame_sequencer_if;
  logic [8:0] out_word;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_word,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_word,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// 16x2 LCD frame sequencer: power-on init command stream, then full-screen
// refresh frames built from a 32-character buffer, sent over valid/ready.
module lcd_frame_sequencer #(
  parameter int PWR_WAIT   = 750000,
  parameter int CLEAR_WAIT = 82000,
  parameter int CNT_W      = 20
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [7:0]            wr_char,
  input  logic                  refresh_req,
  lcd_frame_sequencer_if.master lcd,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_ADDR1,
    S_ROW1,
    S_ADDR2,
    S_ROW2
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_idx, w_idx_next;
  logic [8:0]       r_word, w_word_next;
  logic             r_valid, w_valid_next;
  logic             r_dirty, w_dirty_next;
  logic             r_done, w_done_next;
  logic [7:0]       r_buf [32];

  logic             w_xfer;
  logic [3:0]       w_next_col;
  logic [7:0]       w_row1_char;
  logic [7:0]       w_row2_char;

  function automatic logic [8:0] init_word(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: init_word = 9'h030;
      4'd3:             init_word = 9'h038;
      4'd4:             init_word = 9'h00C;
      4'd5:             init_word = 9'h001;
      default:          init_word = 9'h006;
    endcase
  endfunction

  assign w_xfer      = r_valid && lcd.out_ready;
  assign w_next_col  = r_idx + 4'd1;
  assign w_row1_char = r_buf[{1'b0, w_next_col}];
  assign w_row2_char = r_buf[{1'b1, w_next_col}];

  // Buffer is reset to spaces so a post-reset frame blanks the panel.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= S_PWR_WAIT;
      r_cnt   <= '0;
      r_idx   <= 4'd0;
      r_word  <= 9'h000;
      r_valid <= 1'b0;
      r_dirty <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_word  <= w_word_next;
      r_valid <= w_valid_next;
      r_dirty <= w_dirty_next;
      r_done  <= w_done_next;
    end
  end

  // Every word is registered the cycle before it is presented, so a
  // character is sampled from the buffer once and then held until accepted.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_word_next  = r_word;
    w_valid_next = r_valid;
    w_dirty_next = r_dirty;
    w_done_next  = 1'b0;

    case (r_state)
      S_PWR_WAIT: begin
        if (r_cnt == PWR_LAST) begin
          w_state_next = S_INIT;
          w_cnt_next   = '0;
          w_idx_next   = 4'd0;
          w_valid_next = 1'b1;
          w_word_next  = init_word(4'd0);
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      S_INIT: begin
        if (r_valid) begin
          if (w_xfer) begin
            if (r_idx == 4'd6) begin
              w_state_next = S_IDLE;
              w_valid_next = 1'b0;
            end else if (r_idx == 4'd5) begin
              // Display clear needs extra settling time before entry mode.
              w_valid_next = 1'b0;
              w_cnt_next   = '0;
              w_idx_next   = 4'd6;
            end else begin
              w_idx_next  = w_next_col;
              w_word_next = init_word(w_next_col);
            end
          end
        end else if (r_cnt == CLEAR_LAST) begin
          w_valid_next = 1'b1;
          w_word_next  = init_word(4'd6);
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      S_IDLE: begin
        if (r_dirty || refresh_req) begin
          w_state_next = S_ADDR1;
          w_valid_next = 1'b1;
          w_word_next  = 9'h080;
          w_dirty_next = 1'b0;
        end
      end

      S_ADDR1: begin
        if (w_xfer) begin
          w_state_next = S_ROW1;
          w_idx_next   = 4'd0;
          w_word_next  = {1'b1, r_buf[0]};
        end
      end

      S_ROW1: begin
        if (w_xfer) begin
          w_idx_next = w_next_col;
          if (r_idx == 4'd15) begin
            w_state_next = S_ADDR2;
            w_word_next  = 9'h0C0;
          end else begin
            w_word_next = {1'b1, w_row1_char};
          end
        end
      end

      S_ADDR2: begin
        if (w_xfer) begin
          w_state_next = S_ROW2;
          w_idx_next   = 4'd0;
          w_word_next  = {1'b1, r_buf[16]};
        end
      end

      S_ROW2: begin
        if (w_xfer) begin
          w_idx_next = w_next_col;
          if (r_idx == 4'd15) begin
            w_state_next = S_IDLE;
            w_valid_next = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_word_next = {1'b1, w_row2_char};
          end
        end
      end

      default: begin
        w_state_next = S_PWR_WAIT;
        w_cnt_next   = '0;
        w_valid_next = 1'b0;
      end
    endcase

    // A write landing on the idle-exit cycle must still schedule a frame.
    if (wr_en) begin
      w_dirty_next = 1'b1;
    end
  end

  assign lcd.out_word  = r_word;
  assign lcd.out_valid = r_valid;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_done;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer: init stream, frame contents,
// handshake hold, character sampling, refresh and mid-frame reset.
module tb_lcd_frame_sequencer;

  localparam int PWR_WAIT   = 10;
  localparam int CLEAR_WAIT = 5;

  typedef logic [7:0] buf_t [32];

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       refresh_req;
  logic       busy;
  logic       frame_done;

  lcd_frame_sequencer_if u_if ();

  lcd_frame_sequencer #(
    .PWR_WAIT   (PWR_WAIT),
    .CLEAR_WAIT (CLEAR_WAIT),
    .CNT_W      (20)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .refresh_req (refresh_req),
    .lcd         (u_if),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #10 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [8:0] log_w [$];
  int         log_c [$];
  int         done_cnt = 0;
  int         proto_err = 0;
  logic       pend = 1'b0;
  logic [8:0] pend_word = 9'h000;
  logic       prev_done = 1'b0;
  int         last_xfer_cyc = 0;
  buf_t       mbuf;
  buf_t       snap;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer logger plus hold and frame_done-timing watchdog.
  always @(negedge clk) begin
    if (rst) begin
      pend      = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (pend && !(u_if.out_valid && u_if.out_word == pend_word)) proto_err++;
      if (frame_done) begin
        done_cnt++;
        if (prev_done || (cyc - last_xfer_cyc) != 1) proto_err++;
      end
      prev_done = frame_done;
      if (u_if.out_valid && u_if.out_ready) begin
        log_w.push_back(u_if.out_word);
        log_c.push_back(cyc);
        last_xfer_cyc = cyc;
        pend = 1'b0;
      end else if (u_if.out_valid) begin
        pend      = 1'b1;
        pend_word = u_if.out_word;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_w.delete();
    log_c.delete();
    done_cnt  = 0;
    proto_err = 0;
  endtask

  // Runs until the DUT has been idle for 4 sampled cycles.
  task automatic run_frames(input string tag, input bit toggle);
    bit pat [4];
    int quiet;
    bit ok;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    quiet = 0;
    ok    = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      u_if.out_ready = toggle ? pat[k % 4] : 1'b1;
      @(negedge clk);
      if (busy) quiet = 0;
      else quiet++;
      if (quiet >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    u_if.out_ready = 1'b1;
    chk({tag, "_settle"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_frame(input string tag, input int base, input buf_t b);
    logic [8:0] exp;
    logic [8:0] got;
    for (int k = 0; k < 34; k++) begin
      if (k == 0)       exp = 9'h080;
      else if (k == 17) exp = 9'h0C0;
      else if (k < 17)  exp = {1'b1, b[k-1]};
      else              exp = {1'b1, b[k-2]};
      got = (base + k < log_w.size()) ? log_w[base+k] : 9'h1FF;
      chk($sformatf("%s[%0d]", tag, k), 32'(got), 32'(exp));
    end
  endtask

  task automatic wait_log(input string tag, input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (log_w.size() == n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_wait"}, 32'(ok), 32'd1);
  endtask

  task automatic pulse_refresh();
    tick();
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
  endtask

  // Entered with reset asserted; checks reset values, init stream, first frame.
  task automatic init_seq(input string tag);
    logic [8:0] init_exp [7];
    init_exp = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};
    chk({tag, "_rst_word"},  32'(u_if.out_word),  32'h000);
    chk({tag, "_rst_valid"}, 32'(u_if.out_valid), 32'd0);
    chk({tag, "_rst_busy"},  32'(busy),           32'd1);
    chk({tag, "_rst_done"},  32'(frame_done),     32'd0);
    @(posedge clk);
    #1;
    clear_log();
    rst = 1'b0;
    repeat (PWR_WAIT - 1) tick();
    chk({tag, "_pwr_early"}, 32'(u_if.out_valid), 32'd0);
    tick();
    chk({tag, "_pwr_valid"}, 32'(u_if.out_valid), 32'd1);
    chk({tag, "_pwr_word"},  32'(u_if.out_word),  32'h030);
    run_frames(tag, 1'b0);
    chk({tag, "_nxfer"}, 32'(log_w.size()), 32'd41);
    if (log_w.size() >= 41) begin
      for (int k = 0; k < 7; k++) begin
        chk($sformatf("%s_init[%0d]", tag, k), 32'(log_w[k]), 32'(init_exp[k]));
      end
      chk({tag, "_b2b"},   32'(log_c[1] - log_c[0]), 32'd1);
      chk({tag, "_clear"}, 32'(log_c[6] - log_c[5]), 32'(CLEAR_WAIT + 1));
    end
    chk_frame({tag, "_frame"}, 7, mbuf);
    chk({tag, "_frames"}, 32'(done_cnt),  32'd1);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_proto"},  32'(proto_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = 5'd0;
    wr_char        = 8'h00;
    refresh_req    = 1'b0;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    init_seq("boot");

    // Second write coincides with idle exit, so dirty survives into a follow-up frame.
    clear_log();
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_char = 8'h4C; mbuf[0] = 8'h4C;
    tick();
    wr_addr = 5'd31; wr_char = 8'h45; mbuf[31] = 8'h45;
    tick();
    wr_en = 1'b0;
    run_frames("wr2", 1'b0);
    chk("wr2_nxfer",  32'(log_w.size()), 32'd68);
    chk("wr2_frames", 32'(done_cnt),     32'd2);
    if (log_w.size() >= 34) begin
      chk("wr2_word2",  32'(log_w[1]),  32'h14C);
      chk("wr2_word34", 32'(log_w[33]), 32'h145);
    end
    chk_frame("wr2_f1", 0, mbuf);
    chk_frame("wr2_f2", 34, mbuf);

    for (int i = 0; i < 32; i++) begin
      tick();
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_char = 8'(8'h41 + i);
      mbuf[i] = 8'(8'h41 + i);
    end
    tick();
    wr_en = 1'b0;
    run_frames("fill", 1'b0);

    clear_log();
    pulse_refresh();
    run_frames("toggle", 1'b1);
    chk("toggle_nxfer",  32'(log_w.size()), 32'd34);
    chk("toggle_frames", 32'(done_cnt),     32'd1);
    chk("toggle_proto",  32'(proto_err),    32'd0);
    chk_frame("toggle_f", 0, mbuf);

    clear_log();
    snap = mbuf;
    pulse_refresh();
    wait_log("col3", 4);
    wr_en = 1'b1; wr_addr = 5'd3; wr_char = 8'h7A; mbuf[3] = 8'h7A;
    tick();
    wr_en = 1'b0;
    run_frames("col3", 1'b0);
    chk("col3_nxfer",  32'(log_w.size()), 32'd68);
    chk("col3_frames", 32'(done_cnt),     32'd2);
    if (log_w.size() >= 39) begin
      chk("col3_pending", 32'(log_w[4]),  32'h144);
      chk("col3_refresh", 32'(log_w[38]), 32'h17A);
    end
    chk_frame("col3_f1", 0, snap);
    chk_frame("col3_f2", 34, mbuf);

    clear_log();
    pulse_refresh();
    wait_log("midref", 10);
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    run_frames("midref", 1'b0);
    chk("midref_nxfer",  32'(log_w.size()), 32'd34);
    chk("midref_frames", 32'(done_cnt),     32'd1);

    clear_log();
    pulse_refresh();
    wait_log("row2rst", 20);
    rst = 1'b1;
    #1;
    chk("row2rst_valid", 32'(u_if.out_valid), 32'd0);
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    init_seq("row2rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
